// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the fp_mul arbiter (FSM states, FP32 width, defaults).
// The optional round-robin mode is selected in fp_mul_arb with FP_MUL_ARB_RR_EN.
package fp_mul_arb_pkg;

  localparam int FP32_W    = 32;
  localparam int DEF_N_REQ = 2;
  localparam int DEF_TAG_W = 4;
  localparam int ID_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    RESP
  } state_e;

  // Pointer to the requester after 'id', wrapping at n.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int n);
    return (int'(id) == n - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/fp_mul_rr_arb.sv
// Combinational grant select: first set request at or after ptr_i, wrapping.
// A pointer of zero gives plain lowest-index-first priority.
module fp_mul_rr_arb
  import fp_mul_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  id_o
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] req_rot;
  logic               found;
  int                 sel;

  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl >> ptr_i;
    found   = 1'b0;
    sel     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sel   = (int'(ptr_i) + k) % N_REQ;
      end
    end
    gnt_o = {{(N_REQ-1){1'b0}}, found} << sel;
    id_o  = ID_W'(sel);
  end

endmodule

// File: rtl/fp_mul_arb.sv
// Shares one multi-cycle fp_mul among N_REQ requesters, one operation in flight at a time.
// Define FP_MUL_ARB_RR_EN for round-robin grants; otherwise lowest index wins.
module fp_mul_arb
  import fp_mul_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*FP32_W-1:0]   i_req_a,
  input  logic [N_REQ*FP32_W-1:0]   i_req_b,
  input  logic [N_REQ*TAG_W-1:0]    i_req_tag,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [TAG_W-1:0]          o_rsp_tag,
  output logic [FP32_W-1:0]         o_rsp_result,
  output logic                      o_mul_valid,
  output logic [FP32_W-1:0]         o_mul_a,
  output logic [FP32_W-1:0]         o_mul_b,
  input  logic                      i_mul_valid,
  input  logic [FP32_W-1:0]         i_mul_result
);

  state_e             state_q;
  logic [FP32_W-1:0]  a_q, b_q, res_q;
  logic [TAG_W-1:0]   tag_q;
  logic [ID_W-1:0]    id_q;
  logic               mul_vld_q;
  logic               rsp_vld_q;

  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    ptr;

`ifdef FP_MUL_ARB_RR_EN
  logic [ID_W-1:0]    ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  fp_mul_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (ptr),
    .gnt_o (gnt),
    .id_o  (gnt_id)
  );

  // Accept is same-cycle with the request; masked while reset is held.
  assign o_req_ready  = (i_rst_n && state_q == IDLE) ? gnt : '0;
  assign o_mul_valid  = mul_vld_q;
  assign o_mul_a      = a_q;
  assign o_mul_b      = b_q;
  assign o_rsp_valid  = rsp_vld_q;
  assign o_rsp_id     = id_q;
  assign o_rsp_tag    = tag_q;
  assign o_rsp_result = res_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      id_q      <= '0;
      mul_vld_q <= 1'b0;
      rsp_vld_q <= 1'b0;
`ifdef FP_MUL_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|i_req_valid) begin
            a_q       <= i_req_a[FP32_W*int'(gnt_id) +: FP32_W];
            b_q       <= i_req_b[FP32_W*int'(gnt_id) +: FP32_W];
            tag_q     <= i_req_tag[TAG_W*int'(gnt_id) +: TAG_W];
            id_q      <= gnt_id;
            mul_vld_q <= 1'b1;
            state_q   <= ISSUE;
`ifdef FP_MUL_ARB_RR_EN
            ptr_q     <= next_ptr(gnt_id, N_REQ);
`endif
          end
        end
        ISSUE: begin
          mul_vld_q <= 1'b0;
          state_q   <= WAIT_LOW;
        end
        // The multiplier's done flag from the previous op lingers one cycle after launch.
        WAIT_LOW: begin
          if (!i_mul_valid) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_mul_valid) begin
            res_q     <= i_mul_result;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arb.sv
// Self-checking bench for fp_mul_arb with a 24-cycle behavioural multiplier and a response scoreboard.
module tb_fp_mul_arb;

  localparam int N_REQ = 2;
  localparam int TAG_W = 4;
  localparam int LAT   = 27;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic [N_REQ-1:0]      i_req_valid = '0;
  logic [N_REQ-1:0]      o_req_ready;
  logic [N_REQ*32-1:0]   i_req_a = '0;
  logic [N_REQ*32-1:0]   i_req_b = '0;
  logic [N_REQ*TAG_W-1:0] i_req_tag = '0;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready = 1'b0;
  logic [1:0]            o_rsp_id;
  logic [TAG_W-1:0]      o_rsp_tag;
  logic [31:0]           o_rsp_result;
  logic                  o_mul_valid;
  logic [31:0]           o_mul_a;
  logic [31:0]           o_mul_b;
  logic                  i_mul_valid = 1'b0;
  logic [31:0]           i_mul_result = '0;

  fp_mul_arb #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .i_req_tag    (i_req_tag),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_tag    (o_rsp_tag),
    .o_rsp_result (o_rsp_result),
    .o_mul_valid  (o_mul_valid),
    .o_mul_a      (o_mul_a),
    .o_mul_b      (o_mul_b),
    .i_mul_valid  (i_mul_valid),
    .i_mul_result (i_mul_result)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]       id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    int               lat;
  } rec_t;

  rec_t exp_q[$];
  rec_t rsp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_pulses = 0;
  int mul_pulses = 0;
  int rsp_rises = 0;
  int onehot_bad = 0;
  int same_cycle_gnt = 0;
  int oper_changed = 0;
  int last_gnt_cyc = 0;
  int last_hs_cyc = -1;
  int rise_cyc = 0;
  int gnt_ids[$];
  logic prev_rsp = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Normal-range FP32 multiply through double precision (exact for the operands used here).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    real ra, rb, rp;
    logic [63:0] d;
    ra = (a[30:0] == 0) ? 0.0 : $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0});
    rb = (b[30:0] == 0) ? 0.0 : $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'b0});
    rp = ra * rb;
    d  = $realtobits(rp);
    if (d[62:0] == 0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Multiplier model: done flag lingers one cycle after launch, result 24 cycles later.
  logic        mul_busy = 1'b0;
  int          mul_cnt = 0;
  logic [31:0] ma = '0, mb = '0;
  always @(posedge i_clk) begin
    if (o_mul_valid) begin
      mul_busy <= 1'b1;
      mul_cnt  <= 0;
      ma       <= o_mul_a;
      mb       <= o_mul_b;
    end else if (mul_busy) begin
      if (mul_cnt == 0) i_mul_valid <= 1'b0;
      if (o_mul_a !== ma || o_mul_b !== mb) oper_changed <= oper_changed + 1;
      if (mul_cnt == 23) begin
        i_mul_valid  <= 1'b1;
        i_mul_result <= fmul(ma, mb);
        mul_busy     <= 1'b0;
      end
      mul_cnt <= mul_cnt + 1;
    end
  end

  // Monitor: grants, multiplier launches, and accepted responses.
  always @(negedge i_clk) begin
    rec_t r;
    if (o_req_ready != '0) begin
      rdy_pulses++;
      if (!$onehot(o_req_ready)) onehot_bad++;
      if (cyc == last_hs_cyc) same_cycle_gnt++;
      gnt_ids.push_back(o_req_ready[1] ? 1 : 0);
      last_gnt_cyc = cyc;
    end
    if (o_mul_valid) mul_pulses++;
    if (o_rsp_valid && !prev_rsp) begin
      rsp_rises++;
      rise_cyc = cyc;
    end
    prev_rsp = o_rsp_valid;
    if (o_rsp_valid && i_rsp_ready) begin
      r.id  = o_rsp_id;
      r.tag = o_rsp_tag;
      r.res = o_rsp_result;
      r.lat = rise_cyc - last_gnt_cyc;
      rsp_q.push_back(r);
      last_hs_cyc = cyc;
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_grant_drop(input int r0);
    for (int k = 0; k < 20 && rdy_pulses == r0; k++) next_cycle();
    i_req_valid = '0;
  endtask

  task automatic wait_rsp(input int n, input int bound);
    for (int k = 0; k < bound && rsp_q.size() < n; k++) next_cycle();
  endtask

  task automatic test_reset();
    i_req_valid = 2'b11;
    #12;
    checks++;
    if (o_req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b want=00", o_req_ready); end
    checks++;
    if ({o_mul_valid, o_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_valids mul=%b rsp=%b want 0", o_mul_valid, o_rsp_valid);
    end
    checks++;
    if ({o_rsp_id, o_rsp_tag, o_rsp_result, o_mul_a, o_mul_b} !== '0) begin
      failures++; $display("FAIL reset_payload id=%0d tag=%0d res=%h a=%h b=%h want 0",
                           o_rsp_id, o_rsp_tag, o_rsp_result, o_mul_a, o_mul_b);
    end
    i_req_valid = '0;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    rec_t e, g;
    int r0, m0;
    e.id = 0; e.tag = 5; e.res = 32'h40400000; e.lat = LAT;
    exp_q.push_back(e);
    r0 = rdy_pulses; m0 = mul_pulses;
    i_req_a[31:0] = 32'h3FC00000;
    i_req_b[31:0] = 32'h40000000;
    i_req_tag[TAG_W-1:0] = 4'd5;
    i_rsp_ready = 1'b1;
    i_req_valid = 2'b01;
    wait_grant_drop(r0);
    wait_rsp(1, 80);
    next_cycle();
    checks++;
    if (rsp_q.size() == 0) begin
      failures++; $display("FAIL single_timeout got=no response want=1 response");
      exp_q.delete();
    end else begin
      g = rsp_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g.id !== e.id) begin failures++; $display("FAIL single_id got=%0d want=%0d", g.id, e.id); end
      checks++; if (g.tag !== e.tag) begin failures++; $display("FAIL single_tag got=%0d want=%0d", g.tag, e.tag); end
      checks++; if (g.res !== e.res) begin failures++; $display("FAIL single_result got=%h want=%h", g.res, e.res); end
      checks++; if (g.lat != e.lat) begin failures++; $display("FAIL single_latency got=%0d want=%0d", g.lat, e.lat); end
    end
    checks++;
    if (rdy_pulses - r0 != 1) begin failures++; $display("FAIL single_ready_pulses got=%0d want=1", rdy_pulses - r0); end
    checks++;
    if (mul_pulses - m0 != 1) begin failures++; $display("FAIL single_mul_pulses got=%0d want=1", mul_pulses - m0); end
  endtask

  task automatic test_contention();
    rec_t e, g;
    int r0, oc0;
    int ids[4];
    logic [31:0] res0, res1;
`ifdef FP_MUL_ARB_RR_EN
    ids = '{0, 1, 0, 1};
`else
    ids = '{0, 0, 0, 0};
`endif
    i_req_a = {32'h3F000000, 32'h40000000};
    i_req_b = {32'h41000000, 32'h40400000};
    i_req_tag = {4'd2, 4'd1};
    res0 = fmul(32'h40000000, 32'h40400000);
    res1 = fmul(32'h3F000000, 32'h41000000);
    for (int i = 0; i < 4; i++) begin
      e.id = 2'(ids[i]);
      e.tag = (ids[i] == 0) ? 4'd1 : 4'd2;
      e.res = (ids[i] == 0) ? res0 : res1;
      e.lat = LAT;
      exp_q.push_back(e);
    end
    r0 = rdy_pulses; oc0 = oper_changed;
    i_rsp_ready = 1'b1;
    i_req_valid = 2'b11;
    for (int k = 0; k < 400 && rsp_q.size() < 4; k++) begin
      next_cycle();
      if (rdy_pulses - r0 >= 4) i_req_valid = '0;
    end
    i_req_valid = '0;
    repeat (3) next_cycle();
    checks++;
    if (rsp_q.size() != 4) begin
      failures++; $display("FAIL contention_count got=%0d want=4", rsp_q.size());
      rsp_q.delete(); exp_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        g = rsp_q.pop_front(); e = exp_q.pop_front();
        checks++; if (g.id !== e.id) begin failures++; $display("FAIL contention_id[%0d] got=%0d want=%0d", i, g.id, e.id); end
        checks++; if (g.tag !== e.tag) begin failures++; $display("FAIL contention_tag[%0d] got=%0d want=%0d", i, g.tag, e.tag); end
        checks++; if (g.res !== e.res) begin failures++; $display("FAIL contention_result[%0d] got=%h want=%h", i, g.res, e.res); end
        checks++; if (g.lat != e.lat) begin failures++; $display("FAIL contention_latency[%0d] got=%0d want=%0d", i, g.lat, e.lat); end
      end
    end
    checks++;
    if (rdy_pulses - r0 != 4) begin failures++; $display("FAIL contention_grants got=%0d want=4", rdy_pulses - r0); end
    checks++;
    if (same_cycle_gnt != 0) begin failures++; $display("FAIL grant_in_resp_cycle got=%0d want=0", same_cycle_gnt); end
    checks++;
    if (onehot_bad != 0) begin failures++; $display("FAIL ready_onehot got=%0d want=0", onehot_bad); end
    checks++;
    if (oper_changed != oc0) begin failures++; $display("FAIL operands_unstable got=%0d want=0", oper_changed - oc0); end
  endtask

  task automatic test_rsp_stall();
    rec_t e, g;
    int r0, m0, bad;
    logic [1:0] sid; logic [TAG_W-1:0] stag; logic [31:0] sres;
    e.id = 1; e.tag = 9; e.res = 32'h3F800000; e.lat = LAT;
    exp_q.push_back(e);
    i_req_a[63:32] = 32'h40800000;
    i_req_b[63:32] = 32'h3E800000;
    i_req_tag[2*TAG_W-1:TAG_W] = 4'd9;
    i_rsp_ready = 1'b0;
    r0 = rdy_pulses;
    i_req_valid = 2'b10;
    wait_grant_drop(r0);
    for (int k = 0; k < 60 && !o_rsp_valid; k++) next_cycle();
    sid = o_rsp_id; stag = o_rsp_tag; sres = o_rsp_result;
    r0 = rdy_pulses; m0 = mul_pulses; bad = 0;
    i_req_valid = 2'b01;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (o_rsp_valid !== 1'b1 || o_rsp_id !== sid || o_rsp_tag !== stag || o_rsp_result !== sres ||
          o_req_ready !== 2'b00 || o_mul_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_stability got=%0d bad cycles want=0", bad); end
    checks++;
    if (rdy_pulses != r0 || mul_pulses != m0) begin
      failures++; $display("FAIL stall_activity grants=%0d launches=%0d want 0 0", rdy_pulses - r0, mul_pulses - m0);
    end
    i_req_valid = '0;
    i_rsp_ready = 1'b1;
    wait_rsp(1, 5);
    checks++;
    if (rsp_q.size() == 0) begin
      failures++; $display("FAIL stall_timeout got=no response want=1 response"); exp_q.delete();
    end else begin
      g = rsp_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.id !== e.id || g.tag !== e.tag || g.res !== e.res || g.lat != e.lat) begin
        failures++; $display("FAIL stall_payload got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                             g.id, g.tag, g.res, g.lat, e.id, e.tag, e.res, e.lat);
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    rec_t e, g;
    int r0, rr0;
    i_req_a[31:0] = 32'h40A00000;
    i_req_b[31:0] = 32'h40000000;
    i_req_tag[TAG_W-1:0] = 4'd3;
    i_rsp_ready = 1'b1;
    r0 = rdy_pulses;
    i_req_valid = 2'b01;
    wait_grant_drop(r0);
    repeat (10) next_cycle();
    checks++;
    if (o_mul_a !== 32'h40A00000) begin failures++; $display("FAIL midop_operand got=%h want=40a00000", o_mul_a); end
    rr0 = rsp_rises;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_req_ready, o_mul_valid, o_rsp_valid, o_rsp_id, o_rsp_tag, o_rsp_result, o_mul_a, o_mul_b} !== '0) begin
      failures++; $display("FAIL async_reset_outputs rsp_vld=%b id=%0d tag=%0d res=%h a=%h b=%h want 0",
                           o_rsp_valid, o_rsp_id, o_rsp_tag, o_rsp_result, o_mul_a, o_mul_b);
    end
    #2 i_rst_n = 1'b1;
    repeat (30) next_cycle();
    checks++;
    if (rsp_rises != rr0 || rsp_q.size() != 0) begin
      failures++; $display("FAIL stale_done_ignored got=%0d responses want=0", rsp_rises - rr0);
      rsp_q.delete();
    end
    e.id = 0; e.tag = 7; e.res = fmul(32'h3F800000, 32'h40E00000); e.lat = LAT;
    exp_q.push_back(e);
    i_req_a = {32'h40400000, 32'h3F800000};
    i_req_b = {32'h40400000, 32'h40E00000};
    i_req_tag = {4'd8, 4'd7};
    r0 = rdy_pulses;
    i_req_valid = 2'b11;
    wait_grant_drop(r0);
    wait_rsp(1, 80);
    checks++;
    if (rsp_q.size() == 0) begin
      failures++; $display("FAIL post_reset_timeout got=no response want=1 response"); exp_q.delete();
    end else begin
      g = rsp_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g.id !== e.id) begin failures++; $display("FAIL post_reset_id got=%0d want=%0d", g.id, e.id); end
      checks++; if (g.tag !== e.tag) begin failures++; $display("FAIL post_reset_tag got=%0d want=%0d", g.tag, e.tag); end
      checks++; if (g.res !== e.res) begin failures++; $display("FAIL post_reset_result got=%h want=%h", g.res, e.res); end
      checks++; if (g.lat != e.lat) begin failures++; $display("FAIL post_reset_latency got=%0d want=%0d", g.lat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rsp_stall();
    test_reset_mid();
    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
